load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: converts core lb/lw/sb/sw into single-beat bus accesses.
// The core stalls until the access completes, faults on misalignment, or times out.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  localparam logic [16:0] TO = 17'(TIMEOUT);

  state_t          state, state_nx;
  logic [15:0]     cnt;
  logic            lat_we, lat_word;
  logic [31:0]     lat_addr, lat_wdata;
  logic [3:0][7:0] rd_lane;
  logic [3:0]      be_byte;
  logic            legal, timeout;

  assign legal   = (funct3 == 3'b000) || (funct3 == 3'b010 && addr[1:0] == 2'b00);
  // Abort on the cycle whose wait would bring the count up to TIMEOUT.
  assign timeout = (state == REQ) && !bus_ready && (({1'b0, cnt} + 17'd1) == TO);
  assign rd_lane = bus_rdata;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_be
      assign be_byte[i] = (lat_addr[1:0] == 2'(i));
    end
  endgenerate

  assign bus_we    = lat_we;
  assign bus_addr  = {lat_addr[31:2], 2'b00};
  assign bus_be    = lat_word ? 4'hF : be_byte;
  assign bus_wdata = lat_word ? lat_wdata : {4{lat_wdata[7:0]}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mem_req) state_nx = legal ? REQ : DONE;
      REQ:     if (bus_ready || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall     = (state == REQ) || (state == IDLE && mem_req);
    bus_valid = (state == REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      rdata     <= '0;
      fault     <= 1'b0;
      lat_we    <= 1'b0;
      lat_word  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: if (mem_req) begin
          if (legal) begin
            lat_we    <= mem_we;
            lat_word  <= funct3[1];
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= '0;
          end else begin
            fault <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ready) begin
            if (!lat_we) rdata <= lat_word ? bus_rdata : {24'h0, rd_lane[lat_addr[1:0]]};
            cnt <= '0;
          end else if (timeout) begin
            rdata <= '0;
            fault <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations queued at issue, checked at completion.
module tb_load_store_unit;
  logic        clk, reset, mem_req, mem_we, stall, fault, bus_valid, bus_ready, bus_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int nerr = 0;
  int nchk = 0;
  logic [31:0] exp_rd;

  typedef struct {
    logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] bwdata;
    logic [31:0] rdata; logic fault; int nvalid;
  } exp_t;

  typedef struct {
    bit done; bit stall_idle; bit valid_idle; bit stable; int nvalid; int nstall;
    logic [31:0] addr; logic [3:0] be; logic bwe; logic [31:0] bwdata;
    logic [31:0] rdata; logic fault; logic fault_after; logic [31:0] rdata_after;
  } obs_t;

  exp_t sbq[$];

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] lane(input logic [31:0] d, input logic [1:0] s);
    return 8'(d >> {s, 3'b000});
  endfunction

  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] brd, input int waits,
                            output obs_t o);
    o = '{default: 0};
    o.stable = 1;
    @(negedge clk);
    mem_req = 1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 0; bus_rdata = brd;
    #1 o.stall_idle = stall; o.valid_idle = bus_valid;
    @(negedge clk);
    mem_req = 0; mem_we = ~we; addr = ~a; wdata = ~wd;
    for (int k = 0; k < 64; k++) begin
      bus_ready = (k >= waits);
      #1;
      if (bus_valid) begin
        if (o.nvalid == 0) begin
          o.addr = bus_addr; o.be = bus_be; o.bwe = bus_we; o.bwdata = bus_wdata;
        end else if (o.addr !== bus_addr || o.be !== bus_be || o.bwe !== bus_we || o.bwdata !== bus_wdata) begin
          o.stable = 0;
        end
        o.nvalid++;
      end
      if (stall) o.nstall++;
      else begin
        o.done = 1; o.rdata = rdata; o.fault = fault;
        break;
      end
      @(negedge clk);
    end
    bus_ready = 0;
    @(negedge clk);
    #1 o.fault_after = fault; o.rdata_after = rdata;
  endtask

  task automatic test_reset();
    reset = 0; mem_req = 0; mem_we = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_ready = 0; bus_rdata = 0;
    #3;
    nchk++; if (bus_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b exp=0", bus_valid); end
    nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got=%b exp=0", stall); end
    nchk++; if (fault !== 1'b0) begin nerr++; $display("FAIL rst_fault got=%b exp=0", fault); end
    nchk++; if (rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    mem_req = 1;
    #1;
    nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL rst_stall_req got=%b exp=1", stall); end
    mem_req = 0;
    @(negedge clk);
    #2 reset = 1;
    exp_rd = 32'h0;
  endtask

  task automatic test_lw();
    obs_t o; exp_t e;
    sbq.push_back('{addr: 32'h100, be: 4'hF, we: 1'b0, bwdata: 32'h0,
                    rdata: 32'hDEADBEEF, fault: 1'b0, nvalid: 1});
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, o);
    e = sbq.pop_front();
    nchk++; if (!o.done) begin nerr++; $display("FAIL lw_done got=0 exp=1"); end
    nchk++; if (o.stall_idle !== 1'b1 || o.valid_idle !== 1'b0) begin nerr++; $display("FAIL lw_idle stall=%b valid=%b exp 1/0", o.stall_idle, o.valid_idle); end
    nchk++; if (o.nvalid != e.nvalid || o.nstall != 1) begin nerr++; $display("FAIL lw_latency valid=%0d stall=%0d exp %0d/1", o.nvalid, o.nstall, e.nvalid); end
    nchk++; if (o.addr !== e.addr || o.be !== e.be || o.bwe !== e.we) begin nerr++; $display("FAIL lw_bus addr=%h be=%b we=%b exp %h/%b/%b", o.addr, o.be, o.bwe, e.addr, e.be, e.we); end
    nchk++; if (o.rdata !== e.rdata || o.fault !== e.fault) begin nerr++; $display("FAIL lw_rdata got=%h/%b exp=%h/%b", o.rdata, o.fault, e.rdata, e.fault); end
    nchk++; if (o.rdata_after !== e.rdata) begin nerr++; $display("FAIL lw_hold got=%h exp=%h", o.rdata_after, e.rdata); end
    exp_rd = e.rdata;
  endtask

  task automatic test_lb();
    obs_t o; exp_t e;
    sbq.push_back('{addr: 32'h100, be: 4'b1000, we: 1'b0, bwdata: 32'h0,
                    rdata: {24'h0, lane(32'h80FF1234, 2'd3)}, fault: 1'b0, nvalid: 1});
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, o);
    e = sbq.pop_front();
    nchk++; if (o.addr !== e.addr || o.be !== e.be) begin nerr++; $display("FAIL lb_bus addr=%h be=%b exp %h/%b", o.addr, o.be, e.addr, e.be); end
    nchk++; if (!o.done || o.rdata !== e.rdata) begin nerr++; $display("FAIL lb_rdata got=%h exp=%h", o.rdata, e.rdata); end
    exp_rd = e.rdata;
  endtask

  task automatic test_sb_wait();
    obs_t o; exp_t e;
    sbq.push_back('{addr: 32'h200, be: 4'b0010, we: 1'b1, bwdata: 32'hA5A5A5A5,
                    rdata: exp_rd, fault: 1'b0, nvalid: 4});
    run_access(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h12345678, 3, o);
    e = sbq.pop_front();
    nchk++; if (o.be !== e.be || o.bwdata !== e.bwdata || o.bwe !== e.we) begin nerr++; $display("FAIL sb_bus be=%b wd=%h we=%b exp %b/%h/%b", o.be, o.bwdata, o.bwe, e.be, e.bwdata, e.we); end
    nchk++; if (!o.stable) begin nerr++; $display("FAIL sb_stable got=0 exp=1"); end
    nchk++; if (!o.done || o.nvalid != e.nvalid || o.nstall != e.nvalid) begin nerr++; $display("FAIL sb_wait valid=%0d stall=%0d exp %0d", o.nvalid, o.nstall, e.nvalid); end
    nchk++; if (o.rdata !== e.rdata || o.fault !== 1'b0) begin nerr++; $display("FAIL sb_rdata got=%h/%b exp=%h/0", o.rdata, o.fault, e.rdata); end
  endtask

  task automatic test_illegal();
    obs_t o; exp_t e;
    logic [2:0] f3s [2] = '{3'b010, 3'b001};
    logic [31:0] as [2] = '{32'h102, 32'h100};
    for (int n = 0; n < 2; n++) begin
      sbq.push_back('{addr: 32'h0, be: 4'h0, we: 1'b0, bwdata: 32'h0,
                      rdata: exp_rd, fault: 1'b1, nvalid: 0});
      run_access(1'b0, f3s[n], as[n], 32'h0, 32'hFFFFFFFF, 0, o);
      e = sbq.pop_front();
      nchk++; if (o.nvalid != 0 || o.nstall != 0 || o.stall_idle !== 1'b1) begin nerr++; $display("FAIL ill%0d_bus valid=%0d stall=%0d/%b exp 0/0/1", n, o.nvalid, o.nstall, o.stall_idle); end
      nchk++; if (!o.done || o.fault !== e.fault || o.fault_after !== 1'b0) begin nerr++; $display("FAIL ill%0d_fault got=%b,%b exp=1,0", n, o.fault, o.fault_after); end
      nchk++; if (o.rdata !== e.rdata) begin nerr++; $display("FAIL ill%0d_rdata got=%h exp=%h", n, o.rdata, e.rdata); end
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    sbq.push_back('{addr: 32'h500, be: 4'hF, we: 1'b0, bwdata: 32'h0,
                    rdata: 32'h0, fault: 1'b1, nvalid: 4});
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 1000, o);
    e = sbq.pop_front();
    nchk++; if (o.nvalid != e.nvalid || o.nstall != e.nvalid) begin nerr++; $display("FAIL to_cycles valid=%0d stall=%0d exp %0d", o.nvalid, o.nstall, e.nvalid); end
    nchk++; if (!o.done || o.fault !== e.fault || o.rdata !== e.rdata) begin nerr++; $display("FAIL to_result fault=%b rdata=%h exp %b/%h", o.fault, o.rdata, e.fault, e.rdata); end
    nchk++; if (o.fault_after !== 1'b0) begin nerr++; $display("FAIL to_pulse got=%b exp=0", o.fault_after); end
    exp_rd = e.rdata;
  endtask

  task automatic test_reset_mid_req();
    obs_t o; exp_t e;
    @(negedge clk);
    mem_req = 1; mem_we = 0; funct3 = 3'b010; addr = 32'h400; bus_ready = 0;
    @(negedge clk);
    mem_req = 0;
    #1;
    nchk++; if (bus_valid !== 1'b1) begin nerr++; $display("FAIL mid_valid got=%b exp=1", bus_valid); end
    #2 reset = 0;
    #1;
    nchk++; if (bus_valid !== 1'b0 || stall !== 1'b0 || fault !== 1'b0) begin nerr++; $display("FAIL mid_abort valid=%b stall=%b fault=%b exp 0/0/0", bus_valid, stall, fault); end
    @(negedge clk);
    #1;
    nchk++; if (bus_valid !== 1'b0 || fault !== 1'b0) begin nerr++; $display("FAIL mid_idle valid=%b fault=%b exp 0/0", bus_valid, fault); end
    #1 reset = 1;
    exp_rd = 32'h0;
    sbq.push_back('{addr: 32'h404, be: 4'hF, we: 1'b0, bwdata: 32'h0,
                    rdata: 32'h12345678, fault: 1'b0, nvalid: 2});
    run_access(1'b0, 3'b010, 32'h404, 32'h0, 32'h12345678, 1, o);
    e = sbq.pop_front();
    nchk++; if (!o.done || o.rdata !== e.rdata || o.fault !== e.fault || o.nvalid != e.nvalid) begin nerr++; $display("FAIL mid_next rdata=%h fault=%b valid=%0d exp %h/%b/%0d", o.rdata, o.fault, o.nvalid, e.rdata, e.fault, e.nvalid); end
    exp_rd = e.rdata;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic isword, we;
    logic [31:0] a, wd, brd, bw, rd;
    logic [3:0] be;
    int waits;
    for (int n = 0; n < 10; n++) begin
      isword = 1'($urandom_range(0, 1));
      we     = 1'($urandom_range(0, 1));
      a      = 32'h1000 + ($urandom & 32'hFC) + (isword ? 32'd0 : 32'($urandom_range(0, 3)));
      wd     = $urandom;
      brd    = $urandom;
      waits  = $urandom_range(0, 2);
      be     = isword ? 4'hF : (4'b0001 << a[1:0]);
      bw     = isword ? wd : {4{wd[7:0]}};
      rd     = we ? exp_rd : (isword ? brd : {24'h0, lane(brd, a[1:0])});
      sbq.push_back('{addr: {a[31:2], 2'b00}, be: be, we: we, bwdata: bw,
                      rdata: rd, fault: 1'b0, nvalid: waits + 1});
      run_access(we, isword ? 3'b010 : 3'b000, a, wd, brd, waits, o);
      e = sbq.pop_front();
      nchk++; if (o.addr !== e.addr || o.be !== e.be || o.bwe !== e.we) begin nerr++; $display("FAIL b2b%0d_bus addr=%h be=%b we=%b exp %h/%b/%b", n, o.addr, o.be, o.bwe, e.addr, e.be, e.we); end
      if (e.we) begin
        nchk++; if (o.bwdata !== e.bwdata) begin nerr++; $display("FAIL b2b%0d_wdata got=%h exp=%h", n, o.bwdata, e.bwdata); end
      end
      nchk++; if (!o.done || o.nvalid != e.nvalid || o.fault !== e.fault) begin nerr++; $display("FAIL b2b%0d_ctl valid=%0d fault=%b exp %0d/%b", n, o.nvalid, o.fault, e.nvalid, e.fault); end
      nchk++; if (o.rdata !== e.rdata) begin nerr++; $display("FAIL b2b%0d_rdata got=%h exp=%h", n, o.rdata, e.rdata); end
      exp_rd = e.rdata;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sb_wait();
    test_illegal();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
